// File: rtl/axi_slave_mem_if.sv
// AXI4 AW/W/B + AR/R channel bundle between the bridge (master)
// and the memory-model responder (slave).
interface axi_slave_mem_if #(
  parameter int DW   = 64,
  parameter int AW   = 32,
  parameter int TIDW = 1
);
  logic [TIDW-1:0] axi_aw_id_i;
  logic [AW-1:0]   axi_aw_addr_i;
  logic [7:0]      axi_aw_len_i;
  logic [2:0]      axi_aw_size_i;
  logic [1:0]      axi_aw_burst_i;
  logic            axi_aw_valid_i;
  logic            axi_aw_ready_o;

  logic [DW-1:0]   axi_w_data_i;
  logic [DW/8-1:0] axi_w_strb_i;
  logic            axi_w_last_i;
  logic            axi_w_valid_i;
  logic            axi_w_ready_o;

  logic [TIDW-1:0] axi_b_id_o;
  logic [1:0]      axi_b_resp_o;
  logic            axi_b_valid_o;
  logic            axi_b_ready_i;

  logic [TIDW-1:0] axi_ar_id_i;
  logic [AW-1:0]   axi_ar_addr_i;
  logic [7:0]      axi_ar_len_i;
  logic [2:0]      axi_ar_size_i;
  logic [1:0]      axi_ar_burst_i;
  logic            axi_ar_valid_i;
  logic            axi_ar_ready_o;

  logic [TIDW-1:0] axi_r_id_o;
  logic [DW-1:0]   axi_r_data_o;
  logic [1:0]      axi_r_resp_o;
  logic            axi_r_last_o;
  logic            axi_r_valid_o;
  logic            axi_r_ready_i;

  modport master (
    output axi_aw_id_i, axi_aw_addr_i, axi_aw_len_i,
    output axi_aw_size_i, axi_aw_burst_i, axi_aw_valid_i,
    input  axi_aw_ready_o,
    output axi_w_data_i, axi_w_strb_i, axi_w_last_i,
    output axi_w_valid_i,
    input  axi_w_ready_o,
    input  axi_b_id_o, axi_b_resp_o, axi_b_valid_o,
    output axi_b_ready_i,
    output axi_ar_id_i, axi_ar_addr_i, axi_ar_len_i,
    output axi_ar_size_i, axi_ar_burst_i, axi_ar_valid_i,
    input  axi_ar_ready_o,
    input  axi_r_id_o, axi_r_data_o, axi_r_resp_o,
    input  axi_r_last_o, axi_r_valid_o,
    output axi_r_ready_i
  );

  modport slave (
    input  axi_aw_id_i, axi_aw_addr_i, axi_aw_len_i,
    input  axi_aw_size_i, axi_aw_burst_i, axi_aw_valid_i,
    output axi_aw_ready_o,
    input  axi_w_data_i, axi_w_strb_i, axi_w_last_i,
    input  axi_w_valid_i,
    output axi_w_ready_o,
    output axi_b_id_o, axi_b_resp_o, axi_b_valid_o,
    input  axi_b_ready_i,
    input  axi_ar_id_i, axi_ar_addr_i, axi_ar_len_i,
    input  axi_ar_size_i, axi_ar_burst_i, axi_ar_valid_i,
    output axi_ar_ready_o,
    output axi_r_id_o, axi_r_data_o, axi_r_resp_o,
    output axi_r_last_o, axi_r_valid_o,
    input  axi_r_ready_i
  );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI memory-model responder: byte-strobed word memory behind
// independent write and read FSMs with programmable B/R latency.
module axi_slave_mem #(
  parameter int DW        = 64,
  parameter int AW        = 32,
  parameter int TIDW      = 1,
  parameter int MEM_DEPTH = 1024,
  parameter int B_LATENCY = 3,
  parameter int R_LATENCY = 1
) (
  input logic            HCLK,
  input logic            HRESETn,
  axi_slave_mem_if.slave axi
);
  localparam int SB = DW / 8;
  localparam int BL = $clog2(SB);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = 16;

  typedef struct packed {
    logic [TIDW-1:0] id;
    logic [AW-1:0]   addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
  } cmd_t;

  logic [DW-1:0] mem [MEM_DEPTH] = '{default: '0};

  function automatic logic in_range(input logic [AW-1:0] a);
    return (a >> BL) < AW'(MEM_DEPTH);
  endfunction

  function automatic logic [IW-1:0] idx(input logic [AW-1:0] a);
    return IW'(a >> BL);
  endfunction

  function automatic logic [DW:0] rd_word(input logic [AW-1:0] a);
    if (in_range(a)) return {1'b0, mem[idx(a)]};
    return {1'b1, {DW{1'b0}}};
  endfunction

  function automatic logic [AW-1:0] nxt_addr(
    input logic [AW-1:0] a,
    input logic [7:0]    len,
    input logic [2:0]    size,
    input logic [1:0]    burst
  );
    logic [AW-1:0] incr, msk;
    logic          wrap_ok;
    incr    = AW'(1) << size;
    msk     = (AW'({1'b0, len} + 9'd1) << size) - AW'(1);
    wrap_ok = (len == 8'd1) || (len == 8'd3) ||
              (len == 8'd7) || (len == 8'd15);
    nxt_addr = a + incr;
    if (burst == 2'b00) nxt_addr = a;
    else if (burst == 2'b10 && wrap_ok)
      nxt_addr = (a & ~msk) | ((a + incr) & msk);
  endfunction

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_st_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_st_t;

  w_st_t         ws;
  cmd_t          wc;
  logic [7:0]    wbeat;
  logic          werr;
  logic [CW-1:0] bcnt;

  r_st_t         rs;
  cmd_t          rc;
  cmd_t          ar_cmd;
  logic [7:0]    rbeat;
  logic [CW-1:0] rcnt;
  logic [DW-1:0] rdata;
  logic          rerr;
  logic [AW-1:0] r_nxt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_ok;

  assign aw_hs = axi.axi_aw_valid_i & axi.axi_aw_ready_o;
  assign w_hs  = axi.axi_w_valid_i  & axi.axi_w_ready_o;
  assign b_hs  = axi.axi_b_ready_i  & axi.axi_b_valid_o;
  assign ar_hs = axi.axi_ar_valid_i & axi.axi_ar_ready_o;
  assign r_hs  = axi.axi_r_ready_i  & axi.axi_r_valid_o;
  assign w_ok  = in_range(wc.addr);
  assign r_nxt = nxt_addr(rc.addr, rc.len, rc.size, rc.burst);

  assign ar_cmd = '{
    id:    axi.axi_ar_id_i,
    addr:  axi.axi_ar_addr_i,
    len:   axi.axi_ar_len_i,
    size:  axi.axi_ar_size_i,
    burst: axi.axi_ar_burst_i
  };

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ws    <= W_IDLE;
      wc    <= '0;
      wbeat <= '0;
      werr  <= 1'b0;
      bcnt  <= '0;
    end else begin
      unique case (ws)
        W_IDLE: if (aw_hs) begin
          ws    <= W_DATA;
          wc    <= '{
            id:    axi.axi_aw_id_i,
            addr:  axi.axi_aw_addr_i,
            len:   axi.axi_aw_len_i,
            size:  axi.axi_aw_size_i,
            burst: axi.axi_aw_burst_i
          };
          wbeat <= '0;
          werr  <= 1'b0;
        end
        W_DATA: if (w_hs) begin
          wbeat   <= wbeat + 8'd1;
          wc.addr <= nxt_addr(wc.addr, wc.len, wc.size, wc.burst);
          // WLAST must coincide exactly with the final beat
          if (!w_ok || (axi.axi_w_last_i != (wbeat == wc.len)))
            werr <= 1'b1;
          if (wbeat == wc.len) begin
            ws   <= (B_LATENCY == 0) ? W_RESP : W_WAIT;
            bcnt <= CW'((B_LATENCY > 0) ? B_LATENCY - 1 : 0);
          end
        end
        W_WAIT: begin
          if (bcnt == '0) ws <= W_RESP;
          else            bcnt <= bcnt - CW'(1);
        end
        W_RESP: if (b_hs) ws <= W_IDLE;
        default: ws <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn && w_hs && w_ok) begin
      for (int i = 0; i < SB; i++)
        if (axi.axi_w_strb_i[i])
          mem[idx(wc.addr)][8*i +: 8] <= axi.axi_w_data_i[8*i +: 8];
    end
  end

  // rdata is captured so RDATA stays stable while RREADY is low
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rs    <= R_IDLE;
      rc    <= '0;
      rbeat <= '0;
      rcnt  <= '0;
      rdata <= '0;
      rerr  <= 1'b0;
    end else begin
      unique case (rs)
        R_IDLE: if (ar_hs) begin
          rc    <= ar_cmd;
          rbeat <= '0;
          if (R_LATENCY == 0) begin
            rs            <= R_DATA;
            {rerr, rdata} <= rd_word(ar_cmd.addr);
          end else begin
            rs   <= R_WAIT;
            rcnt <= CW'((R_LATENCY > 0) ? R_LATENCY - 1 : 0);
          end
        end
        R_WAIT: begin
          if (rcnt == '0) begin
            rs            <= R_DATA;
            {rerr, rdata} <= rd_word(rc.addr);
          end else begin
            rcnt <= rcnt - CW'(1);
          end
        end
        R_DATA: if (r_hs) begin
          if (rbeat == rc.len) begin
            rs <= R_IDLE;
          end else begin
            rbeat         <= rbeat + 8'd1;
            rc.addr       <= r_nxt;
            {rerr, rdata} <= rd_word(r_nxt);
          end
        end
        default: rs <= R_IDLE;
      endcase
    end
  end

  assign axi.axi_aw_ready_o = HRESETn & (ws == W_IDLE);
  assign axi.axi_w_ready_o  = HRESETn & (ws == W_DATA);
  assign axi.axi_b_valid_o  = HRESETn & (ws == W_RESP);
  assign axi.axi_b_id_o     = HRESETn ? wc.id : '0;
  assign axi.axi_b_resp_o   = (HRESETn & werr) ? 2'b10 : 2'b00;

  assign axi.axi_ar_ready_o = HRESETn & (rs == R_IDLE);
  assign axi.axi_r_valid_o  = HRESETn & (rs == R_DATA);
  assign axi.axi_r_id_o     = HRESETn ? rc.id : '0;
  assign axi.axi_r_data_o   = HRESETn ? rdata : '0;
  assign axi.axi_r_resp_o   = (HRESETn & rerr) ? 2'b10 : 2'b00;
  assign axi.axi_r_last_o   = axi.axi_r_valid_o & (rbeat == rc.len);
endmodule
